// File: rtl/instr_dispatcher_pkg.sv
// Shared SoftMC instruction encoding: field widths, opcode position and values,
// and the dispatcher state type.
package instr_dispatcher_pkg;

    localparam int SMC_INSTR_WIDTH  = 32;
    localparam int SMC_WAIT_WIDTH   = 28;
    localparam int SMC_OPCODE_LSB   = 28;
    localparam int SMC_OPCODE_WIDTH = 4;

    localparam logic [SMC_OPCODE_WIDTH-1:0] OP_END  = 4'h0;
    localparam logic [SMC_OPCODE_WIDTH-1:0] OP_WAIT = 4'h1;
    localparam logic [SMC_OPCODE_WIDTH-1:0] OP_DDR  = 4'h4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_DONE
    } state_e;

    function automatic logic [SMC_OPCODE_WIDTH-1:0] get_opcode(
        input logic [SMC_INSTR_WIDTH-1:0] instr
    );
        return instr[SMC_OPCODE_LSB +: SMC_OPCODE_WIDTH];
    endfunction

endpackage

// File: rtl/instr_wait_counter.sv
// Down-counter for WAIT expansion: loaded with N-1, flags expiry when it
// reaches 1 and parks at 0, so even the largest WAIT count cannot wrap.
module instr_wait_counter
    import instr_dispatcher_pkg::*;
#(
    parameter int WIDTH = SMC_WAIT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] count_in,
    output logic             expire
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= count_in;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign expire = (r_count == WIDTH'(1));

endmodule

// File: rtl/instr_dispatcher.sv
// Pops SoftMC instructions, forwards DDR commands as registered dec_en pulses,
// expands WAITs into idle slots and ends on END. Optional: SOFTMC_ILLEGAL_OP_EN.
module instr_dispatcher
    import instr_dispatcher_pkg::*;
#(
    parameter int INSTR_WIDTH = SMC_INSTR_WIDTH,
    parameter int WAIT_WIDTH  = SMC_WAIT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    output logic                   dec_en,
    output logic [INSTR_WIDTH-1:0] dec_instr,
    output logic                   busy,
    output logic                   done,
    output logic                   err_illegal
);

    state_e                      r_state;
    state_e                      w_next_state;
    logic                        r_instr_ready;
    logic                        r_dec_en;
    logic [INSTR_WIDTH-1:0]      r_dec_instr;
    logic                        r_busy;
    logic                        r_done;
    logic                        w_accept;
    logic                        w_forward;
    logic                        w_cnt_load;
    logic                        w_cnt_expire;
    logic                        w_wait_long;
    logic [SMC_OPCODE_WIDTH-1:0] w_opcode;
    logic [WAIT_WIDTH-1:0]       w_wait_n;
`ifdef SOFTMC_ILLEGAL_OP_EN
    logic                        w_flag_illegal;
    logic                        r_err_illegal;
`endif

    // instr_ready is high exactly in FETCH, so this is the pop handshake.
    assign w_accept    = r_instr_ready & instr_valid;
    assign w_opcode    = get_opcode(instr_in);
    assign w_wait_n    = instr_in[WAIT_WIDTH-1:0];
    assign w_wait_long = (w_wait_n > WAIT_WIDTH'(1));

    instr_wait_counter #(
        .WIDTH(WAIT_WIDTH)
    ) u_wait_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (w_cnt_load),
        .count_in(w_wait_n - WAIT_WIDTH'(1)),
        .expire  (w_cnt_expire)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_next_state = r_state;
        w_forward    = 1'b0;
        w_cnt_load   = 1'b0;
`ifdef SOFTMC_ILLEGAL_OP_EN
        w_flag_illegal = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                if (w_accept) begin
                    if (w_opcode == OP_DDR) begin
                        w_forward = 1'b1;
                    end else if (w_opcode == OP_WAIT) begin
                        // WAIT 0 and WAIT 1 both cost exactly the one slot spent accepting them.
                        if (w_wait_long) begin
                            w_next_state = ST_WAIT;
                            w_cnt_load   = 1'b1;
                        end
                    end else if (w_opcode == OP_END) begin
                        w_next_state = ST_DONE;
                    end
`ifdef SOFTMC_ILLEGAL_OP_EN
                    else begin
                        w_next_state   = ST_DONE;
                        w_flag_illegal = 1'b1;
                    end
`endif
                end
            end
            ST_WAIT: begin
                if (w_cnt_expire) w_next_state = ST_FETCH;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so the decoder sees clean flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_instr_ready <= 1'b0;
            r_dec_en      <= 1'b0;
            r_dec_instr   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            // NOTE: state and output registers use non-blocking assignments so all flops update together.
            r_state       <= w_next_state;
            r_instr_ready <= (w_next_state == ST_FETCH);
            r_dec_en      <= w_forward;
            r_busy        <= (w_next_state == ST_FETCH) || (w_next_state == ST_WAIT);
            r_done        <= (w_next_state == ST_DONE);
            if (w_forward) r_dec_instr <= instr_in;
        end
    end

`ifdef SOFTMC_ILLEGAL_OP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_illegal <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_err_illegal <= 1'b0;
        end else if (w_flag_illegal) begin
            r_err_illegal <= 1'b1;
        end
    end

    assign err_illegal = r_err_illegal;
`else
    assign err_illegal = 1'b0;
`endif

    assign instr_ready = r_instr_ready;
    assign dec_en      = r_dec_en;
    assign dec_instr   = r_dec_instr;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_instr_dispatcher.sv
// Self-checking bench for instr_dispatcher: FIFO model, DDR scoreboard and
// a vector table of short programs, plus reset and start-at-DONE sequences.
module tb_instr_dispatcher;

    localparam logic [31:0] I_END = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        dec_en;
    logic [31:0] dec_instr;
    logic        busy;
    logic        done;
    logic        err_illegal;

    instr_dispatcher dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .instr_in   (instr_in),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .dec_en     (dec_en),
        .dec_instr  (dec_instr),
        .busy       (busy),
        .done       (done),
        .err_illegal(err_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][31:0] prog;
        int               len;
        int               stall_after;
        int               stall_cycles;
        int               exp_pulses;
        int               exp_gap;
        int               exp_ready_low;
        logic             exp_err;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    int          gap_q[$];
    int          cyc = 0;
    int          pulse_cnt, done_cnt, last_pulse_cyc, done_cyc;
    int          ready_low_run, ready_low_max;
    logic        done_busy;
    logic [31:0] last_dec = '0;
    int          pops, stall_left, cur_sa, cur_sc;
    logic        acc;
    vec_t        vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: scoreboard pop on dec_en, hold check, pulse/done timing.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            last_dec      = '0;
            ready_low_run = 0;
        end else begin
            if (dec_en) begin
                pulse_cnt++;
                if (pulse_cnt > 1) gap_q.push_back(cyc - last_pulse_cyc);
                last_pulse_cyc = cyc;
                if (exp_q.size() == 0) check("unexpected_dec_en", 32'd1, 32'd0);
                else check("dec_instr", dec_instr, exp_q.pop_front());
            end else begin
                check("dec_instr_hold", dec_instr, last_dec);
            end
            last_dec = dec_instr;
            if (done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = busy;
            end
            if (busy && !instr_ready) begin
                ready_low_run++;
                if (ready_low_run > ready_low_max) ready_low_max = ready_low_run;
            end else begin
                ready_low_run = 0;
            end
        end
    end

    // One cycle of the FIFO model: pop what was accepted, present the next head.
    task automatic step();
        @(negedge clk);
        start = 1'b0;
        if (acc) begin
            void'(fifo_q.pop_front());
            pops++;
            if (pops == cur_sa) stall_left = cur_sc;
        end
        if (stall_left > 0) begin
            instr_valid = 1'b0;
            stall_left--;
        end else begin
            instr_valid = (fifo_q.size() > 0);
        end
        instr_in = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
        acc      = instr_valid & instr_ready;
    endtask

    task automatic setup_run();
        fifo_q.delete();
        exp_q.delete();
        gap_q.delete();
        pulse_cnt = 0; done_cnt = 0; last_pulse_cyc = 0; done_cyc = 0;
        ready_low_run = 0; ready_low_max = 0; done_busy = 1'b0;
        pops = 0; stall_left = 0; cur_sa = 0; cur_sc = 0; acc = 1'b0;
    endtask

    function automatic vec_t mk(input logic [31:0] a, b, c, d, input int len, sa, sc,
                                np, gap, rl, input logic err);
        vec_t v;
        v.prog = '0;
        v.prog[0] = a; v.prog[1] = b; v.prog[2] = c; v.prog[3] = d;
        v.len = len; v.stall_after = sa; v.stall_cycles = sc;
        v.exp_pulses = np; v.exp_gap = gap; v.exp_ready_low = rl; v.exp_err = err;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v, input logic start_at_done);
        logic [31:0] w;
        logic        seen;
        setup_run();
        cur_sa = v.stall_after;
        cur_sc = v.stall_cycles;
        for (int i = 0; i < v.len; i++) fifo_q.push_back(v.prog[i]);
        for (int i = 0; i < v.len; i++) begin
            w = v.prog[i];
            if (w[31:28] == 4'h0) break;
            if (w[31:28] == 4'h4) exp_q.push_back(w);
`ifdef SOFTMC_ILLEGAL_OP_EN
            else if (w[31:28] != 4'h1) break;
`endif
        end
        step();
        start = 1'b1;
        seen  = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            step();
            if (done) begin
                seen = 1'b1;
                if (start_at_done) start = 1'b1;
            end
        end
        check($sformatf("v%0d_done_seen", idx), seen, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("v%0d_idle_busy", idx), busy, 1'b0);
            check($sformatf("v%0d_idle_ready", idx), instr_ready, 1'b0);
        end
        check($sformatf("v%0d_pulse_count", idx), pulse_cnt, v.exp_pulses);
        check($sformatf("v%0d_gap_count", idx), gap_q.size(), v.exp_pulses - 1);
        for (int g = 0; g < gap_q.size(); g++)
            check($sformatf("v%0d_pulse_gap", idx), gap_q[g], v.exp_gap);
        check($sformatf("v%0d_done_count", idx), done_cnt, 1);
        check($sformatf("v%0d_done_after_last_pulse", idx), done_cyc - last_pulse_cyc, 1);
        check($sformatf("v%0d_busy_at_done", idx), done_busy, 1'b0);
        check($sformatf("v%0d_ready_low_run", idx), ready_low_max, v.exp_ready_low);
        check($sformatf("v%0d_err_illegal", idx), err_illegal, v.exp_err);
        check($sformatf("v%0d_scoreboard_empty", idx), exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = mk(32'h4000_0A55, 32'h4000_0B66, I_END, 32'h0, 3, 0, 0, 2, 1, 0, 1'b0);
        vecs[1] = mk(32'h4000_0001, 32'h1000_0005, 32'h4000_0002, I_END, 4, 0, 0, 2, 6, 4, 1'b0);
        vecs[2] = mk(32'h4000_0003, 32'h1000_0000, 32'h4000_0004, I_END, 4, 0, 0, 2, 2, 0, 1'b0);
        vecs[3] = mk(32'h4000_0005, 32'h1000_0001, 32'h4000_0006, I_END, 4, 0, 0, 2, 2, 0, 1'b0);
        vecs[4] = mk(32'h4000_00C1, 32'h4000_00C2, I_END, 32'h0, 3, 1, 3, 2, 4, 0, 1'b0);
`ifdef SOFTMC_ILLEGAL_OP_EN
        vecs[5] = mk(32'h4000_00D1, 32'h7000_0000, 32'h4000_00D2, I_END, 4, 0, 0, 1, 0, 0, 1'b1);
`else
        vecs[5] = mk(32'h4000_00D1, 32'h7000_0000, 32'h4000_00D2, I_END, 4, 0, 0, 2, 2, 0, 1'b0);
`endif
        vecs[6] = mk(32'h4000_00E1, 32'h1000_0002, 32'h4000_00E2, I_END, 4, 0, 0, 2, 3, 1, 1'b0);

        rst = 1'b1; start = 1'b0; instr_valid = 1'b0; instr_in = '0;
        setup_run();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_instr_ready", instr_ready, 1'b0);
        check("reset_dec_en", dec_en, 1'b0);
        check("reset_dec_instr", dec_instr, 32'h0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_err_illegal", err_illegal, 1'b0);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i], i == 0);

        // Reset in the middle of a long WAIT: asynchronous abort, no done, no pop.
        setup_run();
        fifo_q.push_back(32'h4000_00F1);
        fifo_q.push_back(32'h1000_0064);
        fifo_q.push_back(32'h4000_00F2);
        fifo_q.push_back(I_END);
        exp_q.push_back(32'h4000_00F1);
        step();
        start = 1'b1;
        for (int n = 0; n < 50 && pulse_cnt == 0; n++) step();
        check("rst_first_pulse", pulse_cnt, 1);
        repeat (10) step();
        check("wait_busy", busy, 1'b1);
        check("wait_ready", instr_ready, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_instr_ready", instr_ready, 1'b0);
        check("async_rst_dec_en", dec_en, 1'b0);
        check("async_rst_dec_instr", dec_instr, 32'h0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", done, 1'b0);
        check("async_rst_err", err_illegal, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        acc = 1'b0;
        repeat (3) step();
        check("rst_no_done", done_cnt, 0);
        check("rst_fifo_untouched", fifo_q.size(), 2);
        check("rst_no_extra_pulse", pulse_cnt, 1);

        run_vec(7, vecs[0], 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
